// File: rtl/mips_mem_master.sv
// mips_mem_master: CPU-side load/store initiator for a word-wide, byte-enabled data memory.
// Only one request is in flight at a time. Stores respond in 2 cycles, loads in 1+READ_LATENCY, errors in 1.
//
// state    | meaning
// ---------+-------------------------------------------------------------------
// IDLE     | req_ready high, waiting for a request
// ISSUE    | memory read or write strobe is high for this one cycle
// WAIT     | remaining read latency when READ_LATENCY > 1
// RESP     | mem_data_out is valid; response is registered on leaving
// ERR_RESP | illegal op or trapped misalignment; error response registered on leaving
module mips_mem_master #(
    parameter int READ_LATENCY  = 1,
    parameter bit MISALIGN_TRAP = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [3:0]  req_op,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_address,
    output logic        mem_wr_en,
    output logic        mem_read_en,
    output logic [3:0]  mem_byte_en,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out
);
    localparam logic [3:0] OP_LB  = 4'd0;
    localparam logic [3:0] OP_LBU = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LHU = 4'd3;
    localparam logic [3:0] OP_LW  = 4'd4;
    localparam logic [3:0] OP_LWL = 4'd5;
    localparam logic [3:0] OP_LWR = 4'd6;
    localparam logic [3:0] OP_SB  = 4'd8;
    localparam logic [3:0] OP_SH  = 4'd9;
    localparam logic [3:0] OP_SW  = 4'd10;

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_ERR_RESP} state_t;

    state_t      state, nxt_state;
    logic [3:0]  op_q, nxt_op;
    logic [1:0]  lane_q, nxt_lane;
    logic [31:0] rt_q, nxt_rt;
    logic [1:0]  wait_cnt, nxt_wait_cnt;
    logic        nxt_req_ready, nxt_resp_valid, nxt_resp_err, nxt_wr_en, nxt_read_en;
    logic [31:0] nxt_resp_rdata, nxt_address, nxt_data_in;
    logic [3:0]  nxt_byte_en;
    logic        is_load, is_store, is_half, is_word, misalign, accept;

    function automatic logic [31:0] load_result(input logic [3:0]  op,
                                                input logic [1:0]  k,
                                                input logic [31:0] w,
                                                input logic [31:0] rt);
        logic [7:0]  b;
        logic [15:0] h;
        logic [4:0]  sh_r, sh_l;
        logic [31:0] ones;
        b    = w[{k, 3'b000} +: 8];
        h    = k[1] ? w[31:16] : w[15:0];
        sh_r = {k, 3'b000};
        sh_l = {~k, 3'b000};
        ones = '1;
        case (op)
            OP_LB:   load_result = {{24{b[7]}}, b};
            OP_LBU:  load_result = {24'd0, b};
            OP_LH:   load_result = {{16{h[15]}}, h};
            OP_LHU:  load_result = {16'd0, h};
            OP_LW:   load_result = w;
            OP_LWL:  load_result = (w << sh_l) | (rt & ~(ones << sh_l));
            OP_LWR:  load_result = (w >> sh_r) | (rt & ~(ones >> sh_r));
            default: load_result = 32'd0;
        endcase
    endfunction

    always_comb begin
        is_load  = (req_op <= OP_LWR);
        is_store = (req_op == OP_SB) || (req_op == OP_SH) || (req_op == OP_SW);
        is_half  = (req_op == OP_LH) || (req_op == OP_LHU) || (req_op == OP_SH);
        is_word  = (req_op == OP_LW) || (req_op == OP_SW);
        misalign = MISALIGN_TRAP && ((is_half && req_addr[0]) ||
                                     (is_word && (req_addr[1:0] != 2'b00)));
        accept   = req_valid && req_ready;
    end

    always_comb begin
        nxt_state      = state;
        nxt_op         = op_q;
        nxt_lane       = lane_q;
        nxt_rt         = rt_q;
        nxt_wait_cnt   = wait_cnt;
        nxt_resp_valid = 1'b0;
        nxt_resp_err   = 1'b0;
        nxt_resp_rdata = 32'd0;
        nxt_wr_en      = 1'b0;
        nxt_read_en    = 1'b0;
        nxt_address    = mem_address;
        nxt_byte_en    = mem_byte_en;
        nxt_data_in    = mem_data_in;

        case (state)
            S_IDLE: begin
                if (accept) begin
                    nxt_op   = req_op;
                    nxt_lane = req_addr[1:0];
                    nxt_rt   = req_wdata;
                    if (!(is_load || is_store) || misalign) begin
                        nxt_state = S_ERR_RESP;
                    end else begin
                        // strobes are registered here so they are high exactly during ISSUE
                        nxt_state   = S_ISSUE;
                        nxt_address = {req_addr[31:2], 2'b00};
                        if (is_store) begin
                            nxt_wr_en = 1'b1;
                            case (req_op)
                                OP_SB: begin
                                    nxt_byte_en = 4'b0001 << req_addr[1:0];
                                    nxt_data_in = {4{req_wdata[7:0]}};
                                end
                                OP_SH: begin
                                    nxt_byte_en = req_addr[1] ? 4'b1100 : 4'b0011;
                                    nxt_data_in = {2{req_wdata[15:0]}};
                                end
                                default: begin
                                    nxt_byte_en = 4'b1111;
                                    nxt_data_in = req_wdata;
                                end
                            endcase
                        end else begin
                            nxt_read_en = 1'b1;
                            nxt_byte_en = 4'b1111;
                        end
                    end
                end
            end
            S_ISSUE: begin
                if ((op_q <= OP_LWR) && (READ_LATENCY > 1)) begin
                    nxt_state    = S_WAIT;
                    nxt_wait_cnt = 2'(READ_LATENCY - 2);
                end else begin
                    nxt_state = S_RESP;
                end
            end
            S_WAIT: begin
                if (wait_cnt == 2'd0) nxt_state = S_RESP;
                else                  nxt_wait_cnt = wait_cnt - 2'd1;
            end
            S_RESP: begin
                nxt_state      = S_IDLE;
                nxt_resp_valid = 1'b1;
                if (op_q <= OP_LWR)
                    nxt_resp_rdata = load_result(op_q, lane_q, mem_data_out, rt_q);
            end
            S_ERR_RESP: begin
                nxt_state      = S_IDLE;
                nxt_resp_valid = 1'b1;
                nxt_resp_err   = 1'b1;
            end
            default: nxt_state = S_IDLE;
        endcase

        nxt_req_ready = (nxt_state == S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            op_q        <= 4'd0;
            lane_q      <= 2'd0;
            rt_q        <= 32'd0;
            wait_cnt    <= 2'd0;
            req_ready   <= 1'b0;
            resp_valid  <= 1'b0;
            resp_err    <= 1'b0;
            resp_rdata  <= 32'd0;
            mem_wr_en   <= 1'b0;
            mem_read_en <= 1'b0;
            mem_address <= 32'd0;
            mem_byte_en <= 4'd0;
            mem_data_in <= 32'd0;
        end else begin
            state       <= nxt_state;
            op_q        <= nxt_op;
            lane_q      <= nxt_lane;
            rt_q        <= nxt_rt;
            wait_cnt    <= nxt_wait_cnt;
            req_ready   <= nxt_req_ready;
            resp_valid  <= nxt_resp_valid;
            resp_err    <= nxt_resp_err;
            resp_rdata  <= nxt_resp_rdata;
            mem_wr_en   <= nxt_wr_en;
            mem_read_en <= nxt_read_en;
            mem_address <= nxt_address;
            mem_byte_en <= nxt_byte_en;
            mem_data_in <= nxt_data_in;
        end
    end
endmodule
